// File: rtl/dcache_wb_reader_if.sv
// rtl/dcache_wb_reader_if.sv - writeback request, AXI write channels and completion signals
interface dcache_wb_reader_if #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic [ADDR_WIDTH-1:0]      req_addr;
    logic [LINE_WORDS*32-1:0]   line_data;

    logic                       awvalid;
    logic                       awready;
    logic [ADDR_WIDTH-1:0]      awaddr;
    logic [7:0]                 awlen;
    logic [2:0]                 awsize;
    logic [1:0]                 awburst;

    logic                       wvalid;
    logic                       wready;
    logic [31:0]                wdata;
    logic [3:0]                 wstrb;
    logic                       wlast;

    logic                       bvalid;
    logic                       bready;
    logic [1:0]                 bresp;

    logic                       done;
    logic                       err;

    // master: the writeback reader itself; slave: cache plus memory side
    modport master (
        input  req_valid, req_addr, line_data, awready, wready, bvalid, bresp,
        output req_ready, awvalid, awaddr, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready, done, err
    );

    modport slave (
        output req_valid, req_addr, line_data, awready, wready, bvalid, bresp,
        input  req_ready, awvalid, awaddr, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready, done, err
    );
endinterface

// File: rtl/dcache_wb_reader.sv
// rtl/dcache_wb_reader.sv - captures a dirty cache line and writes it out as one INCR burst
module dcache_wb_reader #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_wb_reader_if.master   bus
);
    localparam int CW  = $clog2(LINE_WORDS);
    localparam int OFF = CW + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [CW-1:0]         LAST_BEAT  = CW'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFF) - 1);

    logic [1:0]               state;
    logic [CW-1:0]            cnt;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [LINE_WORDS*32-1:0] line_q;
    logic                     done_q;
    logic                     err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr & ALIGN_MASK;
                        cnt    <= '0;
                        state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.awready) state <= S_DATA;
                end
                S_DATA: begin
                    // counter parks on the last beat so it never wraps inside a burst
                    if (bus.wready) begin
                        if (cnt == LAST_BEAT) state <= S_RESP;
                        else                  cnt   <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.bvalid) begin
                        done_q <= 1'b1;
                        err_q  <= (bus.bresp != 2'b00);
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The data RAM set may be reused right after accept, so keep a private copy.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.req_valid) line_q <= bus.line_data;
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.awvalid   = (state == S_ADDR);
    assign bus.awaddr    = addr_q;
    assign bus.awlen     = 8'(LINE_WORDS - 1);
    assign bus.awsize    = 3'b010;
    assign bus.awburst   = 2'b01;
    assign bus.wvalid    = (state == S_DATA);
    assign bus.wdata     = line_q[{cnt, 5'd0} +: 32];
    assign bus.wstrb     = 4'hF;
    assign bus.wlast     = (state == S_DATA) && (cnt == LAST_BEAT);
    assign bus.bready    = (state == S_RESP);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_dcache_wb_reader.sv
// tb/tb_dcache_wb_reader.sv - directed self-checking bench for dcache_wb_reader
module tb_dcache_wb_reader;
    localparam int LW = 8;
    localparam int AW = 32;

    localparam logic [255:0] LINE_A = 256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011;
    localparam logic [255:0] LINE_B = 256'hCAFE0007_CAFE0006_CAFE0005_CAFE0004_CAFE0003_CAFE0002_CAFE0001_CAFE0000;
    localparam logic [255:0] LINE_C = 256'h80000000_40000000_20000000_10000000_0000000F_000000F0_00000F00_0000F000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_wb_reader_if #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) bus ();

    dcache_wb_reader #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
    endtask

    task automatic do_burst(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [255:0] line, input int aw_delay, input bit wtoggle,
                            input logic [1:0] resp, input bit scramble, input bit hold_req,
                            input bit spur_b, input int exp_lat);
        int c, beats, aw_hs, aw_wait, lat;
        bit aw_done, phase, fin;
        idle_inputs();
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.line_data = line;
        check("req_ready_idle", bus.req_ready, 1);
        tick();
        c = 1;
        if (!hold_req) bus.req_valid = 1'b0;
        if (scramble) bus.line_data = '1;
        beats = 0; aw_hs = 0; aw_wait = 0; lat = 0;
        aw_done = 1'b0; phase = 1'b1; fin = 1'b0;
        while (!fin && c < 200) begin
            idle_inputs();
            if (bus.done) begin
                fin = 1'b1;
                lat = c;
                check("err_pulse", bus.err, (resp != 2'b00));
                bus.req_valid = 1'b0;
            end else begin
                check("req_ready_busy", bus.req_ready, 0);
                check("done_early", bus.done, 0);
                if (bus.wvalid) begin
                    check("w_before_aw", aw_done, 1);
                    check("beat_overrun", beats < LW, 1);
                    check("wdata", bus.wdata, line[(beats % LW)*32 +: 32]);
                    check("wlast", bus.wlast, (beats == LW-1));
                    check("wstrb", bus.wstrb, 4'hF);
                    bus.wready = wtoggle ? phase : 1'b1;
                    phase = ~phase;
                    if (bus.wready) beats++;
                    if (spur_b && beats == 2) bus.bvalid = 1'b1;
                end
                if (bus.awvalid) begin
                    check("aw_repeat", aw_done, 0);
                    check("awaddr", bus.awaddr, exp_addr);
                    check("awlen", bus.awlen, LW-1);
                    check("awsize", bus.awsize, 3'b010);
                    check("awburst", bus.awburst, 2'b01);
                    bus.awready = (aw_wait >= aw_delay);
                    aw_wait++;
                    if (bus.awready) begin
                        aw_done = 1'b1;
                        aw_hs++;
                    end
                end
                if (bus.bready) begin
                    check("b_after_w", beats, LW);
                    bus.bvalid = 1'b1;
                    bus.bresp  = resp;
                end
            end
            tick();
            c++;
        end
        check("done_seen", fin, 1);
        check("beat_count", beats, LW);
        check("aw_handshakes", aw_hs, 1);
        if (exp_lat > 0) check("latency", lat, exp_lat);
        check("done_one_cycle", bus.done, 0);
        check("err_one_cycle", bus.err, 0);
        check("req_ready_after", bus.req_ready, 1);
    endtask

    initial begin
        int n, beats;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.line_data = '0;
        idle_inputs();
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_wlast", bus.wlast, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b0;
        tick();

        do_burst(32'h1F00_0034, 32'h1F00_0020, LINE_A, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11);
        do_burst(32'h0000_07FF, 32'h0000_07E0, LINE_B, 3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        do_burst(32'hFFFF_FFFF, 32'hFFFF_FFE0, LINE_C, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 11);
        do_burst(32'h0000_1000, 32'h0000_1000, LINE_A, 0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 11);
        do_burst(32'h0000_2044, 32'h0000_2040, LINE_B, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11);

        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_3000;
        bus.line_data = LINE_C;
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        beats = 0;
        while (beats < 3 && n < 50) begin
            bus.awready = 1'b1;
            bus.wready  = 1'b1;
            if (bus.wvalid) beats++;
            tick();
            n++;
        end
        check("mid_beats_reached", beats, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_wvalid", bus.wvalid, 0);
        check("mid_rst_awvalid", bus.awvalid, 0);
        check("mid_rst_wlast", bus.wlast, 0);
        check("mid_rst_bready", bus.bready, 0);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        check("mid_release_ready", bus.req_ready, 1);
        check("mid_release_wvalid", bus.wvalid, 0);
        do_burst(32'h0000_3000, 32'h0000_3000, LINE_A, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11);

        do_burst(32'h0000_5010, 32'h0000_5000, LINE_B, 0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 11);
        tick();
        check("hold_no_reaccept", bus.req_ready, 1);
        check("hold_no_awvalid", bus.awvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
